cpu_prog_sequencer: RTL
=======================

Name: cpu_prog_sequencer

Overview:
- Upstream driver for the 4-bit accumulator CPU core: generates that core's entire 8-bit `io_in` bus (command clock, 2-bit command, 4-bit argument).
- Accepts a program as a stream of 32 nibbles over valid/ready: 16 code words, then 16 data words.
- Issues Reset, LoadCode x16, LoadData x16, Reset, then single-steps Run commands.
- Stops on a step budget or on halt detection (pc unchanged across a step), and reports the final {pc, acc}.

Parameters:
- CODE_WORDS, 16, number of LoadCode commands issued.
- DATA_WORDS, 16, number of LoadData commands issued.
- STEP_W, 8, width of step budget and step counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- run_steps  in  STEP_W  max Run commands; latched on accepted start.
- in_valid  in  1  program nibble valid.
- in_ready  out  1  sequencer can accept a nibble this cycle.
- in_data  in  4  program nibble (code word in [1:0], upper bits passed through).
- cpu_io_in  out  8  to core: {cmdarg[3:0], 1'b0, cmd[1:0], cpu_clk}.
- cpu_io_out  in  8  from core: {pc[3:0], acc[3:0]}.
- busy  out  1  high in every state except IDLE/DONE.
- done  out  1  high in DONE until next accepted start or reset.
- halted  out  1  valid with done: run ended by halt detection.
- steps  out  STEP_W  Run commands completed in current/last run.
- result  out  8  cpu_io_out sampled at last HOLD phase.

Behaviour:
- Reset (async, any time incl. mid-command): state IDLE; cpu_io_in=8'h00 (cmd Reset, cpu_clk low); in_ready, busy, done, halted = 0; steps=0; result=0. No strobe is ever left high.
- Command issue, 3 phases, one clock each: SETUP (cmd/cmdarg driven, cpu_clk=0), STROBE (same, cpu_clk=1), HOLD (same, cpu_clk=0). cmd/cmdarg are registered and stable across all three phases. cpu_io_out is sampled in HOLD.
- cmd encoding: Reset=0, LoadCode=1, LoadData=2, Run=3. cmdarg=0 for Reset and Run.
- States, in order:
  - IDLE: on start, latch run_steps, clear done/halted/steps, go to RST1.
  - RST1: one Reset command.
  - CODE: WAIT phase with in_ready=1. Handshake in_valid&&in_ready latches in_data into cmdarg, then SETUP/STROBE/HOLD with LoadCode. Repeat CODE_WORDS times (counter 0..CODE_WORDS-1).
  - DATA: same with LoadData, DATA_WORDS times.
  - RST2: one Reset command; pc_prev=0.
  - RUN: if latched run_steps==0, go straight to DONE with halted=0. Otherwise issue a Run command; in HOLD, steps+=1 and result=cpu_io_out. Then:
    - if pc (cpu_io_out[7:4]) == pc_prev: DONE, halted=1;
    - else if steps==run_steps: DONE, halted=0;
    - else pc_prev=pc and next Run.
  - DONE: done=1; start returns to RST1 with the same clearing as IDLE.
- in_ready is 0 outside the CODE/DATA WAIT phase. Nibbles offered at other times are not consumed. Stalls of any length in WAIT are legal; cpu_io_in holds its last value with cpu_clk=0.
- Per-nibble cost: 4 clocks when in_valid is held high (WAIT+3). A full load with valid held is 3+128+3 = 134 clocks before the first Run.
- start while busy is ignored.
- Step counter never exceeds run_steps, so no wrap.

Test Plan:
- Reset mid-STROBE of a LoadData -> next cycle cpu_io_in=8'h00, busy=0, in_ready=0; a subsequent start completes normally.
- Encoding check, nibble 3 in CODE -> cpu_io_in=8'h33 during STROBE, 8'h32 in SETUP/HOLD. Nibble 7 in DATA -> STROBE 8'h75. Reset strobe -> 8'h01. Run strobe -> 8'h07.
- Program code {0,3,3,...}, data {7,1,0,...}, run_steps=20 with a behavioural core model:
  - Step 1: Load, acc=7, pc=1. Step 2: Bnz to pc 1.
  - Result: done=1, halted=1, steps=2, result=8'h17.
- Same program, run_steps=1 -> done=1, halted=0, steps=1, result=8'h17.
- Same program, run_steps=0 -> done immediately after RST2, steps=0, no Run strobe ever observed.
- Backpressure: in_valid toggled randomly during load -> exactly 32 handshakes, exactly 32 LoadCode/LoadData strobes, each carrying the correct nibble in order. Start pulses during busy are ignored.

Source files
------------

// File: rtl/cpu_prog_sequencer.sv
// Drives the 4-bit accumulator core's io_in bus: resets it, loads a 32-nibble program taken from a
// valid/ready stream, then single-steps Run commands until a step budget is spent or pc stops moving.
module cpu_prog_sequencer #(
    parameter int unsigned CODE_WORDS = 16,
    parameter int unsigned DATA_WORDS = 16,
    parameter int unsigned STEP_W     = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [STEP_W-1:0] run_steps,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_data,
    output logic [7:0]        cpu_io_in,
    input  logic [7:0]        cpu_io_out,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic [STEP_W-1:0] steps,
    output logic [7:0]        result
);

    localparam int unsigned MAX_WORDS = (CODE_WORDS > DATA_WORDS) ? CODE_WORDS : DATA_WORDS;
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);

    localparam logic [1:0] CMD_RESET     = 2'd0;
    localparam logic [1:0] CMD_LOAD_CODE = 2'd1;
    localparam logic [1:0] CMD_LOAD_DATA = 2'd2;
    localparam logic [1:0] CMD_RUN       = 2'd3;

    typedef enum logic [2:0] {StIdle, StRst1, StCode, StData, StRst2, StRun, StDone} state_e;
    typedef enum logic [1:0] {PhWait, PhSetup, PhStrobe, PhHold} phase_e;

    state_e            state_q;
    phase_e            phase_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        cmd_q;
    logic [3:0]        arg_q;
    logic              cpu_clk_q;
    logic [STEP_W-1:0] budget_q;
    logic [STEP_W-1:0] steps_q;
    logic [3:0]        pc_prev_q;
    logic              halted_q;
    logic [7:0]        result_q;

    logic [STEP_W-1:0] steps_inc;
    logic [3:0]        pc;
    logic              code_last;
    logic              data_last;

    assign steps_inc = steps_q + STEP_W'(1);
    assign pc        = cpu_io_out[7:4];
    assign code_last = (cnt_q == CNT_W'(CODE_WORDS - 1));
    assign data_last = (cnt_q == CNT_W'(DATA_WORDS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            phase_q   <= PhSetup;
            cnt_q     <= '0;
            cmd_q     <= CMD_RESET;
            arg_q     <= '0;
            cpu_clk_q <= 1'b0;
            budget_q  <= '0;
            steps_q   <= '0;
            pc_prev_q <= '0;
            halted_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        budget_q  <= run_steps;
                        halted_q  <= 1'b0;
                        steps_q   <= '0;
                        state_q   <= StRst1;
                        phase_q   <= PhSetup;
                        cmd_q     <= CMD_RESET;
                        arg_q     <= '0;
                        cpu_clk_q <= 1'b0;
                    end
                end
                default: begin
                    unique case (phase_q)
                        PhWait: begin
                            // in_ready is high exactly in this phase
                            if (in_valid) begin
                                arg_q   <= in_data;
                                cmd_q   <= (state_q == StCode) ? CMD_LOAD_CODE : CMD_LOAD_DATA;
                                phase_q <= PhSetup;
                            end
                        end
                        PhSetup: begin
                            cpu_clk_q <= 1'b1;
                            phase_q   <= PhStrobe;
                        end
                        PhStrobe: begin
                            cpu_clk_q <= 1'b0;
                            phase_q   <= PhHold;
                        end
                        PhHold: begin
                            case (state_q)
                                StRst1: begin
                                    state_q <= StCode;
                                    phase_q <= PhWait;
                                    cnt_q   <= '0;
                                end
                                StCode: begin
                                    phase_q <= PhWait;
                                    if (code_last) begin
                                        state_q <= StData;
                                        cnt_q   <= '0;
                                    end else begin
                                        cnt_q <= cnt_q + CNT_W'(1);
                                    end
                                end
                                StData: begin
                                    if (data_last) begin
                                        state_q <= StRst2;
                                        phase_q <= PhSetup;
                                        cmd_q   <= CMD_RESET;
                                        arg_q   <= '0;
                                        cnt_q   <= '0;
                                    end else begin
                                        phase_q <= PhWait;
                                        cnt_q   <= cnt_q + CNT_W'(1);
                                    end
                                end
                                StRst2: begin
                                    pc_prev_q <= '0;
                                    if (budget_q == '0) begin
                                        state_q <= StDone;
                                    end else begin
                                        state_q <= StRun;
                                        phase_q <= PhSetup;
                                        cmd_q   <= CMD_RUN;
                                        arg_q   <= '0;
                                    end
                                end
                                StRun: begin
                                    steps_q  <= steps_inc;
                                    result_q <= cpu_io_out;
                                    // Halt check wins over the budget check on the same step
                                    if (pc == pc_prev_q) begin
                                        state_q  <= StDone;
                                        halted_q <= 1'b1;
                                    end else if (steps_inc == budget_q) begin
                                        state_q <= StDone;
                                    end else begin
                                        pc_prev_q <= pc;
                                        phase_q   <= PhSetup;
                                    end
                                end
                                default: state_q <= StIdle;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    assign cpu_io_in = {arg_q, 1'b0, cmd_q, cpu_clk_q};
    assign in_ready  = (phase_q == PhWait);
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign halted    = halted_q;
    assign steps     = steps_q;
    assign result    = result_q;

endmodule
